meanshift_sdiv_24s_16s_seq: RTL and testbench

Sequential signed divider that undoes the weighting done by the 16s×16s→24 multiplier in the mean-shift datapath. It divides a 24-bit signed weighted sum by a 16-bit signed weight sum and produces a 16-bit signed centroid coordinate plus remainder. It produces one quotient bit per cycle with a start/done handshake, so one instance is shared across the x, y and colour channels of the filter kernel.

---
 rtl/meanshift_sdiv_24s_16s_seq_if.sv | 26 ++
 rtl/meanshift_sdiv_24s_16s_seq.sv | 166 ++++++++++++++++
 tb/tb_meanshift_sdiv_24s_16s_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/meanshift_sdiv_24s_16s_seq_if.sv
// Start/done handshake bundle for the mean-shift signed sequential divider.
interface meanshift_sdiv_24s_16s_seq_if #(
  parameter int unsigned DIVIDEND_WIDTH = 24,
  parameter int unsigned DIVISOR_WIDTH  = 16,
  parameter int unsigned QUOT_WIDTH     = 16
);
  logic                      start;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      ready;
  logic                      done;
  logic [QUOT_WIDTH-1:0]     quot;
  logic [DIVISOR_WIDTH-1:0]  remd;
  logic                      ovf;
  logic                      dbz;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quot, remd, ovf, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quot, remd, ovf, dbz
  );
endinterface

// File: rtl/meanshift_sdiv_24s_16s_seq.sv
// Sequential signed divider (24s / 16s -> 16s quotient + 16s remainder).
// One quotient bit per cycle via restoring division on magnitudes; signs,
// saturation and divide-by-zero are resolved in a final fix-up cycle.
module meanshift_sdiv_24s_16s_seq #(
  parameter int unsigned DIVIDEND_WIDTH = 24,
  parameter int unsigned DIVISOR_WIDTH  = 16,
  parameter int unsigned QUOT_WIDTH     = 16
) (
  input logic                        ap_clk,
  input logic                        ap_rst,
  meanshift_sdiv_24s_16s_seq_if.slave io_bus
);
  localparam int unsigned DW = DIVIDEND_WIDTH;
  localparam int unsigned VW = DIVISOR_WIDTH;
  localparam int unsigned QW = QUOT_WIDTH;
  localparam int unsigned CW = $clog2(DW);

  localparam logic [QW-1:0] Q_MAX   = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] Q_MIN   = {1'b1, {(QW-1){1'b0}}};
  localparam logic [DW:0]   MAG_POS = (DW+1)'(Q_MAX);
  localparam logic [DW:0]   MAG_NEG = (DW+1)'(Q_MIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [DW:0]   r_num;     // dividend magnitude, consumed MSB first
  logic [DW:0]   r_quo;     // quotient magnitude, built LSB-in
  logic [VW:0]   r_dvs;     // divisor magnitude
  logic [VW:0]   r_rem;     // partial remainder magnitude
  logic          r_sdvd;
  logic          r_sdvs;
  logic          r_zdiv;
  logic [VW-1:0] r_dvd_lo;  // raw low dividend bits, returned as remainder on /0

  logic          r_ready;
  logic          r_done;
  logic [QW-1:0] r_quot;
  logic [VW-1:0] r_remd;
  logic          r_ovf;
  logic          r_dbz;

  logic [DW:0]   w_dvd_sx;
  logic [DW:0]   w_dvd_abs;
  logic [VW:0]   w_dvs_sx;
  logic [VW:0]   w_dvs_abs;
  logic [VW+1:0] w_part;
  logic [VW+1:0] w_diff;
  logic          w_ge;
  logic          w_neg;
  logic [QW-1:0] w_quot;
  logic [VW-1:0] w_remd;
  logic          w_ovf;

  // Operand magnitudes, sign-extended one bit so -2^(DW-1) stays representable.
  always_comb begin
    w_dvd_sx  = {io_bus.dividend[DW-1], io_bus.dividend};
    w_dvd_abs = w_dvd_sx[DW] ? -w_dvd_sx : w_dvd_sx;
    w_dvs_sx  = {io_bus.divisor[VW-1], io_bus.divisor};
    w_dvs_abs = w_dvs_sx[VW] ? -w_dvs_sx : w_dvs_sx;
  end

  // One restoring-division step: shift in next dividend bit, trial subtract.
  always_comb begin
    w_part = {r_rem, r_num[DW-1]};
    w_ge   = (w_part >= {1'b0, r_dvs});
    w_diff = w_part - {1'b0, r_dvs};
  end

  // Sign application, saturation and divide-by-zero result selection.
  always_comb begin
    w_neg  = r_sdvd ^ r_sdvs;
    w_ovf  = 1'b0;
    w_quot = '0;
    w_remd = '0;
    if (r_zdiv) begin
      w_quot = r_sdvd ? Q_MIN : Q_MAX;
      w_remd = r_dvd_lo;
    end else begin
      w_remd = VW'(r_sdvd ? -r_rem : r_rem);
      if (!w_neg && (r_quo > MAG_POS)) begin
        w_quot = Q_MAX;
        w_ovf  = 1'b1;
      end else if (w_neg && (r_quo > MAG_NEG)) begin
        w_quot = Q_MIN;
        w_ovf  = 1'b1;
      end else begin
        w_quot = QW'(w_neg ? -r_quo : r_quo);
      end
    end
  end

  // Control FSM with datapath and registered result outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_num    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_sdvd   <= 1'b0;
      r_sdvs   <= 1'b0;
      r_zdiv   <= 1'b0;
      r_dvd_lo <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_quot   <= '0;
      r_remd   <= '0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_num    <= w_dvd_abs;
            r_dvs    <= w_dvs_abs;
            r_quo    <= '0;
            r_rem    <= '0;
            r_sdvd   <= io_bus.dividend[DW-1];
            r_sdvs   <= io_bus.divisor[VW-1];
            r_zdiv   <= (io_bus.divisor == '0);
            r_dvd_lo <= io_bus.dividend[VW-1:0];
            r_cnt    <= CW'(DW-1);
            r_ready  <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_num <= r_num << 1;
          r_quo <= {r_quo[DW-1:0], w_ge};
          r_rem <= (VW+1)'(w_ge ? w_diff : w_part);
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_quot  <= w_quot;
          r_remd  <= w_remd;
          r_ovf   <= w_ovf;
          r_dbz   <= r_zdiv;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.ready = r_ready;
  assign io_bus.done  = r_done;
  assign io_bus.quot  = r_quot;
  assign io_bus.remd  = r_remd;
  assign io_bus.ovf   = r_ovf;
  assign io_bus.dbz   = r_dbz;
endmodule

// File: tb/tb_meanshift_sdiv_24s_16s_seq.sv
// Directed self-checking bench for the mean-shift sequential signed divider.
module tb_meanshift_sdiv_24s_16s_seq;
  localparam int unsigned DW = 24;
  localparam int unsigned VW = 16;
  localparam int unsigned QW = 16;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  meanshift_sdiv_24s_16s_seq_if #(
    .DIVIDEND_WIDTH(DW),
    .DIVISOR_WIDTH (VW),
    .QUOT_WIDTH    (QW)
  ) bus ();

  meanshift_sdiv_24s_16s_seq #(
    .DIVIDEND_WIDTH(DW),
    .DIVISOR_WIDTH (VW),
    .QUOT_WIDTH    (QW)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .io_bus(bus.slave)
  );

  always #5 ap_clk = ~ap_clk;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Issue one division from idle; lat = cycles from driving start to the
  // first cycle with done high, or -1 if done never arrives.
  task automatic launch(input logic [DW-1:0] a, input logic [VW-1:0] b, output int lat);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    ap_rst    = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) tick();
    n_tests++;
    if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    n_tests++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_tests++;
    if (bus.quot !== 16'd0) begin n_fail++; $display("FAIL reset_quot: got %h expected 0000", bus.quot); end
    n_tests++;
    if (bus.remd !== 16'd0) begin n_fail++; $display("FAIL reset_remd: got %h expected 0000", bus.remd); end
    n_tests++;
    if (bus.ovf !== 1'b0 || bus.dbz !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got ovf=%b dbz=%b expected 0 0", bus.ovf, bus.dbz);
    end
    ap_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    launch(24'd1000, 16'd7, lat);
    n_tests++;
    if (lat !== 26) begin n_fail++; $display("FAIL basic_latency: got %0d expected 26", lat); end
    n_tests++;
    if (bus.quot !== 16'd142) begin n_fail++; $display("FAIL basic_quot: got %0d expected 142", $signed(bus.quot)); end
    n_tests++;
    if (bus.remd !== 16'd6) begin n_fail++; $display("FAIL basic_remd: got %0d expected 6", $signed(bus.remd)); end
    n_tests++;
    if (bus.ovf !== 1'b0 || bus.dbz !== 1'b0) begin
      n_fail++; $display("FAIL basic_flags: got ovf=%b dbz=%b expected 0 0", bus.ovf, bus.dbz);
    end
    n_tests++;
    if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_with_done: got %b expected 1", bus.ready); end
    repeat (3) tick();
    n_tests++;
    if (bus.quot !== 16'd142 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold: got quot=%0d done=%b expected 142 0", $signed(bus.quot), bus.done);
    end
  endtask

  task automatic test_signs();
    logic [DW-1:0] a_t [3];
    logic [VW-1:0] b_t [3];
    logic [QW-1:0] q_t [3];
    logic [VW-1:0] r_t [3];
    int lat;
    a_t = '{-24'sd1000, 24'sd1000, -24'sd1000};
    b_t = '{16'sd7, -16'sd7, -16'sd7};
    q_t = '{-16'sd142, -16'sd142, 16'sd142};
    r_t = '{-16'sd6, 16'sd6, -16'sd6};
    for (int i = 0; i < 3; i++) begin
      launch(a_t[i], b_t[i], lat);
      n_tests++;
      if (lat !== 26) begin n_fail++; $display("FAIL sign%0d_latency: got %0d expected 26", i, lat); end
      n_tests++;
      if (bus.quot !== q_t[i]) begin
        n_fail++; $display("FAIL sign%0d_quot: got %0d expected %0d", i, $signed(bus.quot), $signed(q_t[i]));
      end
      n_tests++;
      if (bus.remd !== r_t[i]) begin
        n_fail++; $display("FAIL sign%0d_remd: got %0d expected %0d", i, $signed(bus.remd), $signed(r_t[i]));
      end
      n_tests++;
      if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL sign%0d_ovf: got %b expected 0", i, bus.ovf); end
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] a_t [4];
    logic [VW-1:0] b_t [4];
    logic [QW-1:0] q_t [4];
    logic          o_t [4];
    int lat;
    a_t = '{24'sd100000, 24'h800000, 24'h800000, -24'sd32768};
    b_t = '{16'sd1, 16'sd1, -16'sd1, 16'sd1};
    q_t = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
    o_t = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      launch(a_t[i], b_t[i], lat);
      n_tests++;
      if (lat !== 26) begin n_fail++; $display("FAIL ovf%0d_latency: got %0d expected 26", i, lat); end
      n_tests++;
      if (bus.quot !== q_t[i]) begin
        n_fail++; $display("FAIL ovf%0d_quot: got %0d expected %0d", i, $signed(bus.quot), $signed(q_t[i]));
      end
      n_tests++;
      if (bus.ovf !== o_t[i] || bus.dbz !== 1'b0) begin
        n_fail++; $display("FAIL ovf%0d_flags: got ovf=%b dbz=%b expected %b 0", i, bus.ovf, bus.dbz, o_t[i]);
      end
    end
    n_tests++;
    if (bus.remd !== 16'd0) begin n_fail++; $display("FAIL ovf3_remd: got %0d expected 0", $signed(bus.remd)); end
  endtask

  task automatic test_div_by_zero();
    int lat;
    launch(24'sd5, 16'd0, lat);
    n_tests++;
    if (lat !== 26) begin n_fail++; $display("FAIL dbz_pos_latency: got %0d expected 26", lat); end
    n_tests++;
    if (bus.quot !== 16'h7FFF || bus.remd !== 16'd5) begin
      n_fail++; $display("FAIL dbz_pos_result: got quot=%0d remd=%0d expected 32767 5", $signed(bus.quot), $signed(bus.remd));
    end
    n_tests++;
    if (bus.dbz !== 1'b1 || bus.ovf !== 1'b0) begin
      n_fail++; $display("FAIL dbz_pos_flags: got dbz=%b ovf=%b expected 1 0", bus.dbz, bus.ovf);
    end
    launch(-24'sd5, 16'd0, lat);
    n_tests++;
    if (bus.quot !== 16'h8000 || bus.remd !== 16'hFFFB) begin
      n_fail++; $display("FAIL dbz_neg_result: got quot=%0d remd=%0d expected -32768 -5", $signed(bus.quot), $signed(bus.remd));
    end
    n_tests++;
    if (bus.dbz !== 1'b1 || bus.ovf !== 1'b0) begin
      n_fail++; $display("FAIL dbz_neg_flags: got dbz=%b ovf=%b expected 1 0", bus.dbz, bus.ovf);
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    bus.start    = 1'b1;
    bus.dividend = 24'd1000;
    bus.divisor  = 16'd7;
    tick();
    // Busy now: these operands must be ignored.
    bus.dividend = 24'd12345;
    bus.divisor  = 16'd11;
    n_tests++;
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy: got %b expected 0", bus.ready); end
    t1 = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 10) begin
        bus.dividend = 24'd50;
        bus.divisor  = -16'sd3;
      end
      if (bus.done === 1'b1) begin
        t1 = i;
        break;
      end
    end
    n_tests++;
    if (t1 !== 25) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 25", t1); end
    n_tests++;
    if (bus.quot !== 16'd142 || bus.remd !== 16'd6) begin
      n_fail++; $display("FAIL b2b_first_result: got %0d r %0d expected 142 r 6", $signed(bus.quot), $signed(bus.remd));
    end
    tick();
    bus.start = 1'b0;
    n_tests++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_pulse_width: got done=%b ready=%b expected 0 0", bus.done, bus.ready);
    end
    t2 = -1;
    for (int i = 2; i <= 40; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        t2 = i;
        break;
      end
    end
    n_tests++;
    if (t2 !== 26) begin n_fail++; $display("FAIL b2b_done_spacing: got %0d expected 26", t2); end
    n_tests++;
    if (bus.quot !== -16'sd16 || bus.remd !== 16'd2) begin
      n_fail++; $display("FAIL b2b_second_result: got %0d r %0d expected -16 r 2", $signed(bus.quot), $signed(bus.remd));
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int n_done;
    int lat;
    bus.start    = 1'b1;
    bus.dividend = 24'd1000;
    bus.divisor  = 16'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    n_tests++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL abort_handshake: got ready=%b done=%b expected 1 0", bus.ready, bus.done);
    end
    n_tests++;
    if (bus.quot !== 16'd0 || bus.remd !== 16'd0 || bus.ovf !== 1'b0 || bus.dbz !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: got quot=%h remd=%h ovf=%b dbz=%b expected 0000 0000 0 0",
                         bus.quot, bus.remd, bus.ovf, bus.dbz);
    end
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", n_done); end
    launch(24'd1000, 16'd7, lat);
    n_tests++;
    if (lat !== 26 || bus.quot !== 16'd142 || bus.remd !== 16'd6) begin
      n_fail++; $display("FAIL abort_recover: got lat=%0d quot=%0d remd=%0d expected 26 142 6",
                         lat, $signed(bus.quot), $signed(bus.remd));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_by_zero();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
